// File: rtl/systolic_skew_feeder.sv
// rtl/systolic_skew_feeder.sv - diagonal skew feeder for a ROWS x COLS systolic array
// Optional stall statistics: define SKF_STATS_EN.

module skf_skew_chain #(
    parameter int DW    = 8,
    parameter int DEPTH = 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic [DW-1:0] out_data,
    output logic          out_valid
);

    logic [DW-1:0]    d [DEPTH];
    logic [DEPTH-1:0] v;

    // A non-accepted cycle pushes a zero bubble so nothing stale ever reaches the array.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int k = 0; k < DEPTH; k++) d[k] <= '0;
            v <= '0;
        end else begin
            d[0] <= in_valid ? in_data : '0;
            v[0] <= in_valid;
            for (int k = 1; k < DEPTH; k++) begin
                d[k] <= d[k-1];
                v[k] <= v[k-1];
            end
        end
    end

    assign out_data  = v[DEPTH-1] ? d[DEPTH-1] : '0;
    assign out_valid = v[DEPTH-1];

endmodule

module systolic_skew_feeder #(
    parameter int ROWS = 8,
    parameter int COLS = 8,
    parameter int DW   = 8,
    parameter int KW   = 16
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic [KW-1:0]      k_len,
    input  logic [ROWS*DW-1:0] a_vec,
    input  logic               a_valid,
    input  logic [COLS*DW-1:0] w_vec,
    input  logic               w_valid,
    output logic               in_ready,
    output logic [ROWS*DW-1:0] as,
    output logic [COLS*DW-1:0] ws,
    output logic [ROWS-1:0]    a_lv,
    output logic [COLS-1:0]    w_lv,
    output logic               busy,
    output logic               done,
    output logic [KW-1:0]      stall_cnt
);

    localparam int L   = (ROWS > COLS) ? ROWS : COLS;
    localparam int DCW = $clog2(L + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t         state, state_n;
    logic [KW-1:0]  k_lat;
    logic [KW-1:0]  beat_cnt;
    logic [DCW-1:0] drain_cnt;
    logic           done_n;
    logic           hs;

    assign in_ready = (state == S_RUN) && (beat_cnt < k_lat);
    assign busy     = (state != S_IDLE);
    assign hs       = in_ready && a_valid && w_valid;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= S_IDLE;
            done      <= 1'b0;
            k_lat     <= '0;
            beat_cnt  <= '0;
            drain_cnt <= '0;
        end else begin
            state <= state_n;
            done  <= done_n;
            if (state == S_IDLE && start) begin
                k_lat    <= k_len;
                beat_cnt <= '0;
            end else if (hs) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            drain_cnt <= (state == S_DRAIN) ? drain_cnt + 1'b1 : '0;
        end
    end

    // DRAIN lasts L cycles so the last beat has left the longest chain before done.
    always_comb begin
        state_n = state;
        done_n  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (k_len != '0) state_n = S_RUN;
                    else             done_n  = 1'b1;
                end
            end
            S_RUN: begin
                if (hs && beat_cnt == k_lat - 1'b1) state_n = S_DRAIN;
            end
            S_DRAIN: begin
                if (drain_cnt == DCW'(L - 1)) begin
                    state_n = S_IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    for (genvar i = 0; i < ROWS; i++) begin : g_row
        skf_skew_chain #(.DW(DW), .DEPTH(i + 1)) u_chain (
            .clk       (clk),
            .rstn      (rstn),
            .in_valid  (hs),
            .in_data   (a_vec[i*DW +: DW]),
            .out_data  (as[i*DW +: DW]),
            .out_valid (a_lv[i])
        );
    end

    for (genvar j = 0; j < COLS; j++) begin : g_col
        skf_skew_chain #(.DW(DW), .DEPTH(j + 1)) u_chain (
            .clk       (clk),
            .rstn      (rstn),
            .in_valid  (hs),
            .in_data   (w_vec[j*DW +: DW]),
            .out_data  (ws[j*DW +: DW]),
            .out_valid (w_lv[j])
        );
    end

`ifdef SKF_STATS_EN
    logic [KW-1:0] stall_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            stall_q <= '0;
        end else if (state == S_IDLE && start) begin
            stall_q <= '0;
        end else if (in_ready && !hs && stall_q != '1) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// tb/tb_systolic_skew_feeder.sv - table-driven bench for systolic_skew_feeder

module tb_systolic_skew_feeder;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [15:0] k_len;
    logic [31:0] a_vec, w_vec;
    logic        a_valid, w_valid;
    logic        in_ready, busy, done;
    logic [31:0] as, ws;
    logic [3:0]  a_lv, w_lv;
    logic [15:0] stall_cnt;

    logic        start2;
    logic [15:0] k_len2;
    logic [63:0] a_vec2;
    logic [15:0] w_vec2;
    logic        v2;
    logic        in_ready2, busy2, done2;
    logic [63:0] as2;
    logic [15:0] ws2;
    logic [7:0]  a_lv2;
    logic [1:0]  w_lv2;
    logic [15:0] stall_cnt2;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    systolic_skew_feeder #(.ROWS(4), .COLS(4), .DW(8), .KW(16)) dut (
        .clk(clk), .rstn(rstn), .start(start), .k_len(k_len),
        .a_vec(a_vec), .a_valid(a_valid), .w_vec(w_vec), .w_valid(w_valid),
        .in_ready(in_ready), .as(as), .ws(ws), .a_lv(a_lv), .w_lv(w_lv),
        .busy(busy), .done(done), .stall_cnt(stall_cnt)
    );

    systolic_skew_feeder #(.ROWS(8), .COLS(2), .DW(8), .KW(16)) dut2 (
        .clk(clk), .rstn(rstn), .start(start2), .k_len(k_len2),
        .a_vec(a_vec2), .a_valid(v2), .w_vec(w_vec2), .w_valid(v2),
        .in_ready(in_ready2), .as(as2), .ws(ws2), .a_lv(a_lv2), .w_lv(w_lv2),
        .busy(busy2), .done(done2), .stall_cnt(stall_cnt2)
    );

    typedef struct {
        logic        start;
        logic [15:0] k_len;
        logic        av;
        logic        wv;
        int          ib;
        logic [15:0] eb;   // beat index on each lane (nibble per lane, F = empty)
        logic        busy;
        logic        rdy;
        logic        done;
    } vec_t;

    vec_t tbl [21];

    function automatic logic [7:0] aval(int b, int i);
        return 8'(8'h01 + b * 16 + i);
    endfunction

    function automatic logic [7:0] wval(int b, int j);
        return 8'(8'hA0 + b * 16 + j);
    endfunction

    function automatic logic [31:0] pack_a(int b);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = aval(b, i);
        return r;
    endfunction

    function automatic logic [31:0] pack_w(int b);
        logic [31:0] r;
        for (int j = 0; j < 4; j++) r[j*8 +: 8] = wval(b, j);
        return r;
    endfunction

    function automatic logic [31:0] exp_lanes(logic [15:0] eb, bit is_w);
        logic [31:0] r;
        logic [3:0]  nb;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            nb = eb[i*4 +: 4];
            if (nb != 4'hF) r[i*8 +: 8] = is_w ? wval(int'(nb), i) : aval(int'(nb), i);
        end
        return r;
    endfunction

    function automatic logic [3:0] exp_lv(logic [15:0] eb);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = (eb[i*4 +: 4] != 4'hF);
        return r;
    endfunction

    function automatic vec_t mk(logic s, logic [15:0] k, logic av, logic wv, int ib,
                                logic [15:0] eb, logic b, logic r, logic d);
        vec_t v;
        v.start = s; v.k_len = k; v.av = av; v.wv = wv; v.ib = ib;
        v.eb = eb; v.busy = b; v.rdy = r; v.done = d;
        return v;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    int first_done, first_w1, first_a7;
    logic [15:0] exp_stall;

    initial begin
        tbl[0]  = mk(1, 3, 0, 0, 0, 16'hFFFF, 0, 0, 0);
        tbl[1]  = mk(0, 0, 1, 1, 0, 16'hFFFF, 1, 1, 0);
        tbl[2]  = mk(1, 9, 1, 1, 1, 16'hFFF0, 1, 1, 0);
        tbl[3]  = mk(0, 0, 1, 1, 2, 16'hFF01, 1, 1, 0);
        tbl[4]  = mk(0, 0, 1, 1, 7, 16'hF012, 1, 0, 0);
        tbl[5]  = mk(0, 0, 0, 0, 0, 16'h012F, 1, 0, 0);
        tbl[6]  = mk(0, 0, 0, 0, 0, 16'h12FF, 1, 0, 0);
        tbl[7]  = mk(1, 9, 0, 0, 0, 16'h2FFF, 1, 0, 0);
        tbl[8]  = mk(0, 0, 0, 0, 0, 16'hFFFF, 0, 0, 1);
        tbl[9]  = mk(1, 0, 0, 0, 0, 16'hFFFF, 0, 0, 0);
        tbl[10] = mk(1, 2, 0, 0, 0, 16'hFFFF, 0, 0, 1);
        tbl[11] = mk(0, 0, 1, 0, 3, 16'hFFFF, 1, 1, 0);
        tbl[12] = mk(0, 0, 1, 0, 3, 16'hFFFF, 1, 1, 0);
        tbl[13] = mk(0, 0, 1, 1, 3, 16'hFFFF, 1, 1, 0);
        tbl[14] = mk(0, 0, 1, 1, 4, 16'hFFF3, 1, 1, 0);
        tbl[15] = mk(0, 0, 0, 0, 0, 16'hFF34, 1, 0, 0);
        tbl[16] = mk(0, 0, 0, 0, 0, 16'hF34F, 1, 0, 0);
        tbl[17] = mk(0, 0, 0, 0, 0, 16'h34FF, 1, 0, 0);
        tbl[18] = mk(0, 0, 0, 0, 0, 16'h4FFF, 1, 0, 0);
        tbl[19] = mk(0, 0, 0, 0, 0, 16'hFFFF, 0, 0, 1);
        tbl[20] = mk(0, 0, 0, 0, 0, 16'hFFFF, 0, 0, 0);

`ifdef SKF_STATS_EN
        exp_stall = 16'd2;
`else
        exp_stall = 16'd0;
`endif

        rstn = 1'b0; start = 0; k_len = 0; a_vec = 0; w_vec = 0; a_valid = 0; w_valid = 0;
        start2 = 0; k_len2 = 0; a_vec2 = 0; w_vec2 = 0; v2 = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        check("reset_stall_cnt", 64'(stall_cnt), 64'd0);
        check("reset_dut2_ctl", {61'd0, busy2, in_ready2, done2}, 64'd0);

        for (int r = 0; r < 21; r++) begin
            @(negedge clk);
            check($sformatf("row%0d_as", r), 64'(as), 64'(exp_lanes(tbl[r].eb, 1'b0)));
            check($sformatf("row%0d_ws", r), 64'(ws), 64'(exp_lanes(tbl[r].eb, 1'b1)));
            check($sformatf("row%0d_a_lv", r), 64'(a_lv), 64'(exp_lv(tbl[r].eb)));
            check($sformatf("row%0d_w_lv", r), 64'(w_lv), 64'(exp_lv(tbl[r].eb)));
            check($sformatf("row%0d_busy_rdy_done", r), {61'd0, busy, in_ready, done},
                  {61'd0, tbl[r].busy, tbl[r].rdy, tbl[r].done});
            start   = tbl[r].start;
            k_len   = tbl[r].k_len;
            a_valid = tbl[r].av;
            w_valid = tbl[r].wv;
            a_vec   = pack_a(tbl[r].ib);
            w_vec   = pack_w(tbl[r].ib);
        end
        check("stall_cnt_after_bubbles", 64'(stall_cnt), 64'(exp_stall));

        // Reset while draining: outputs flushed, no done, then a fresh job runs.
        @(negedge clk); start = 1; k_len = 1;
        @(negedge clk); start = 0; a_valid = 1; w_valid = 1; a_vec = pack_a(5); w_vec = pack_w(5);
        @(negedge clk); a_valid = 0; w_valid = 0;
        check("drain_busy_before_reset", 64'(busy), 64'd1);
        rstn = 1'b0;
        @(negedge clk); rstn = 1'b1;
        check("post_reset_as_ws", {as, ws}, 64'd0);
        check("post_reset_lv", {56'd0, a_lv, w_lv}, 64'd0);
        check("post_reset_ctl", {61'd0, busy, in_ready, done}, 64'd0);
        first_done = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (done || a_lv != 0) first_done = n + 1;
        end
        check("no_done_after_abort", 64'(first_done), 64'd0);

        start = 1; k_len = 1;
        @(negedge clk); start = 0; a_valid = 1; w_valid = 1; a_vec = pack_a(6); w_vec = pack_w(6);
        @(negedge clk); a_valid = 0; w_valid = 0;
        first_done = 0;
        for (int n = 1; n <= 12 && first_done == 0; n++) begin
            if (n == 4) begin
                check("rerun_lane3_as", 64'(as[31:24]), 64'(aval(6, 3)));
                check("rerun_lane3_ws", 64'(ws[31:24]), 64'(wval(6, 3)));
            end
            if (done) first_done = n;
            if (first_done == 0) @(negedge clk);
        end
        check("rerun_done_latency", 64'(first_done), 64'd5);

        // 8x2 array, k_len=1: col1 at T+2, row7 at T+8, done at T+9.
        start2 = 1; k_len2 = 1;
        @(negedge clk); start2 = 0; v2 = 1;
        for (int i = 0; i < 8; i++) a_vec2[i*8 +: 8] = 8'(8'h70 + i);
        w_vec2 = 16'hC2C1;
        @(negedge clk); v2 = 0;
        first_done = 0; first_w1 = 0; first_a7 = 0;
        for (int n = 1; n <= 14; n++) begin
            if (w_lv2[1] && first_w1 == 0) begin
                first_w1 = n;
                check("r8c2_col1_data", 64'(ws2[15:8]), 64'hC2);
            end
            if (a_lv2[7] && first_a7 == 0) begin
                first_a7 = n;
                check("r8c2_row7_data", 64'(as2[63:56]), 64'h77);
            end
            if (done2 && first_done == 0) first_done = n;
            @(negedge clk);
        end
        check("r8c2_col1_latency", 64'(first_w1), 64'd2);
        check("r8c2_row7_latency", 64'(first_a7), 64'd8);
        check("r8c2_done_latency", 64'(first_done), 64'd9);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
